// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the hazard unit and its in-flight scoreboard.
// Entry rd is stored at RD_W_MAX bits so one entry type serves any REG_ADDR_W <= RD_W_MAX.
package hazard_unit_pkg;

  localparam int RD_W_MAX   = 8;
  localparam int FWD_SEL_RF = 0;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                wen;
    logic                is_load;
  } entry_t;

  function automatic logic is_load_sel(input logic [1:0] wb_sel);
    return wb_sel == WB_MEM;
  endfunction

endpackage

// File: rtl/hazard_unit_inflight_scoreboard.sv
// Shift register of destination info for instructions past decode (entry 1 = EX,
// entry DEPTH = WB). Frozen while hold is high; the caller supplies an invalid entry for bubbles.
module inflight_scoreboard
  import hazard_unit_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  entry_t               insert,
  output entry_t [DEPTH:1]     entries
);

  always_ff @(posedge clk) begin
    if (reset) begin
      entries <= '0;
    end else if (!hold) begin
      entries[1] <= insert;
      for (int k = 2; k <= DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: operand forwarding selects, load-use stall, EX bubble and jump flush.
// Optional HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rf_wen,
  input  logic                  id_is_load,
  input  logic                  ex_jump_flag,
  input  logic                  pipe_hold,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [SEL_W-1:0]      fwd_rs1_sel,
  output logic [SEL_W-1:0]      fwd_rs2_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  entry_t [DEPTH:1] entries;
  entry_t           insert;
  logic             haz_rs1;
  logic             haz_rs2;
  logic             load_use;

  inflight_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .hold    (pipe_hold),
    .insert  (insert),
    .entries (entries)
  );

  // Scan oldest to youngest so the youngest matching stage ends up selected.
  function automatic void resolve(
    input  entry_t [DEPTH:1]      e,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    output logic [SEL_W-1:0]      sel,
    output logic                  haz
  );
    logic hit;
    logic ld;
    int   idx;
    hit = 1'b0;
    ld  = 1'b0;
    idx = 0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (e[k].valid && e[k].wen && used && (rs != '0) && (e[k].rd == RD_W_MAX'(rs))) begin
        hit = 1'b1;
        ld  = e[k].is_load;
        idx = k;
      end
    end
    sel = (hit && (!ld || idx >= LOAD_READY)) ? SEL_W'(idx) : SEL_W'(FWD_SEL_RF);
    haz = hit && ld && (idx < LOAD_READY);
  endfunction

  always_comb begin
    resolve(entries, id_rs1_addr, id_rs1_used, fwd_rs1_sel, haz_rs1);
    resolve(entries, id_rs2_addr, id_rs2_used, fwd_rs2_sel, haz_rs2);
  end

  assign load_use = id_valid && (haz_rs1 || haz_rs2);

  // Priority: global hold, then taken jump, then load-use.
  always_comb begin
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (pipe_hold) begin
      stall_if_id = 1'b1;
    end else if (ex_jump_flag) begin
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else if (load_use) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

  always_comb begin
    insert = '0;
    if (id_valid && !bubble_ex) begin
      insert.valid   = 1'b1;
      insert.rd      = RD_W_MAX'(id_rd_addr);
      insert.wen     = id_rf_wen;
      insert.is_load = id_is_load;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pipe_hold && !ex_jump_flag && load_use && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ex_jump_flag && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
